// File: rtl/logic_gate_unit.sv
// Registered WIDTH-bit logic gate with a DEPTH-entry result FIFO and saturating beat counter.
// Optional head-result reduction flags (y_zero/y_ones) are enabled by defining LOGIC_REDUCE_EN.
module logic_gate_unit #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             y_zero,
   output logic             y_ones,
   output logic [CNT_W-1:0] count
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      OP_AND   = 3'd0,
      OP_OR    = 3'd1,
      OP_XOR   = 3'd2,
      OP_NAND  = 3'd3,
      OP_NOR   = 3'd4,
      OP_XNOR  = 3'd5,
      OP_ANDN  = 3'd6,
      OP_PASSA = 3'd7
   } op_e;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] result;
   logic             full, empty, push, pop;
   op_e              op_sel;

   assign op_sel = op_e'(op);

   always_comb begin
      result = '0;
      unique case (op_sel)
         OP_AND:   result = a & b;
         OP_OR:    result = a | b;
         OP_XOR:   result = a ^ b;
         OP_NAND:  result = ~(a & b);
         OP_NOR:   result = ~(a | b);
         OP_XNOR:  result = ~(a ^ b);
         OP_ANDN:  result = a & ~b;
         OP_PASSA: result = a;
         default:  result = '0;
      endcase
   end

   // Extra wrap bit distinguishes full from empty when the index bits match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign count     = count_q;

   // When drained, y keeps showing the most recently consumed result.
   assign y = empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      last_d   = last_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (count_q != '1) count_d = count_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         last_d   = mem_q[rd_ptr_q[AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         last_q   <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         last_q   <= last_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) mem_q[wr_ptr_q[AW-1:0]] <= result;
   end

`ifdef LOGIC_REDUCE_EN
   logic zero_q [DEPTH];
   logic ones_q [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         zero_q[wr_ptr_q[AW-1:0]] <= ~|result;
         ones_q[wr_ptr_q[AW-1:0]] <= &result;
      end
   end

   assign y_zero = out_valid && zero_q[rd_ptr_q[AW-1:0]];
   assign y_ones = out_valid && ones_q[rd_ptr_q[AW-1:0]];
`else
   assign y_zero = 1'b0;
   assign y_ones = 1'b0;
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit: directed tables, corner sequences and a random run
// checked every cycle against a queue-based reference model.
module tb_logic_gate_unit;

   localparam int W    = 8;
   localparam int D    = 2;
   localparam int CW   = 4;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_ready, out_valid, out_ready, y_zero, y_ones;
   logic [2:0]    op;
   logic [W-1:0]  a, b, y;
   logic [CW-1:0] count;

   int n_cmp = 0;
   int n_bad = 0;

   logic [W-1:0] q_m [$];
   logic [W-1:0] last_m = '0;
   int           cnt_m  = 0;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] y;
   } vec_t;

   vec_t tbl [8];

   logic_gate_unit #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y),
      .y_zero(y_zero), .y_ones(y_ones), .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
      case (o)
         3'd0: return x & z;
         3'd1: return x | z;
         3'd2: return x ^ z;
         3'd3: return ~(x & z);
         3'd4: return ~(x | z);
         3'd5: return ~(x ^ z);
         3'd6: return x & ~z;
         default: return x;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic         ev;
      logic [W-1:0] ey;
      ev = (q_m.size() != 0);
      ey = ev ? q_m[0] : last_m;
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("in_ready", 32'(in_ready), 32'(q_m.size() < D));
      chk("y", 32'(y), 32'(ey));
      chk("count", 32'(count), 32'(cnt_m));
`ifdef LOGIC_REDUCE_EN
      chk("y_zero", 32'(y_zero), 32'(ev && (ey == '0)));
      chk("y_ones", 32'(y_ones), 32'(ev && (ey == '1)));
`else
      chk("y_zero", 32'(y_zero), 32'(0));
      chk("y_ones", 32'(y_ones), 32'(0));
`endif
   endtask

   // One clock with inputs already driven; returns 1 time unit after the rising edge.
   task automatic cycle(input bit do_check);
      bit           push, pop;
      logic [W-1:0] res;
      @(negedge clk);
      if (do_check) check_model();
      push = in_valid && (q_m.size() < D);
      pop  = out_ready && (q_m.size() != 0);
      res  = ref_op(op, a, b);
      @(posedge clk);
      if (rst) begin
         q_m.delete();
         last_m = '0;
         cnt_m  = 0;
      end else begin
         if (pop) last_m = q_m.pop_front();
         if (push) begin
            q_m.push_back(res);
            if (cnt_m < MAXC) cnt_m++;
         end
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
      in_valid = v; op = o; a = x; b = z;
   endtask

   initial begin
      tbl[0] = '{3'd0, 8'hF0, 8'hCC, 8'hC0};
      tbl[1] = '{3'd1, 8'hF0, 8'hCC, 8'hFC};
      tbl[2] = '{3'd2, 8'hF0, 8'hCC, 8'h3C};
      tbl[3] = '{3'd3, 8'hF0, 8'hCC, 8'h3F};
      tbl[4] = '{3'd4, 8'hF0, 8'hCC, 8'h03};
      tbl[5] = '{3'd5, 8'hF0, 8'hCC, 8'hC3};
      tbl[6] = '{3'd6, 8'hF0, 8'hCC, 8'h30};
      tbl[7] = '{3'd7, 8'hF0, 8'hCC, 8'hF0};

      // Reset then idle
      rst = 1'b1; out_ready = 1'b0;
      drive(1'b0, 3'd0, '0, '0);
      cycle(1'b0);
      cycle(1'b0);
      rst = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      cycle(1'b1);

      // Op sweep, consumer always ready
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
         cycle(1'b1);
         chk($sformatf("sweep_y%0d", i), 32'(y), 32'(tbl[i].y));
         chk($sformatf("sweep_v%0d", i), 32'(out_valid), 32'd1);
      end
      drive(1'b0, 3'd0, '0, '0);
      cycle(1'b1);
      chk("sweep_count", 32'(count), 32'd8);

      // Backpressure until full, held third beat, then drain in order
      out_ready = 1'b0;
      drive(1'b1, 3'd0, 8'hFF, 8'h0F);
      cycle(1'b1);
      drive(1'b1, 3'd1, 8'h01, 8'h02);
      cycle(1'b1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      drive(1'b1, 3'd2, 8'h0F, 8'hF0);
      cycle(1'b1);
      cycle(1'b1);
      chk("bp_count", 32'(count), 32'd10);
      chk("bp_head", 32'(y), 32'h0F);
      out_ready = 1'b1;
      cycle(1'b1);
      chk("bp_second", 32'(y), 32'h03);
      chk("bp_ready_again", 32'(in_ready), 32'd1);
      cycle(1'b1);
      chk("bp_third", 32'(y), 32'hFF);
      chk("bp_count3", 32'(count), 32'd11);
      drive(1'b0, 3'd0, '0, '0);
      cycle(1'b1);
      cycle(1'b1);

      // Simultaneous push/pop at occupancy 1 across pointer wrap
      out_ready = 1'b0;
      drive(1'b1, 3'd7, 8'h11, 8'h00);
      cycle(1'b1);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 3'd7, 8'(8'h20 + i), 8'h00);
         cycle(1'b1);
         chk($sformatf("pp_y%0d", i), 32'(y), 32'(8'h20 + i));
         chk($sformatf("pp_ready%0d", i), 32'(in_ready), 32'd1);
      end
      drive(1'b0, 3'd0, '0, '0);
      cycle(1'b1);

      // Counter saturation
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 3'(i), 8'(i * 37), 8'(i * 91));
         cycle(1'b1);
      end
      chk("count_sat", 32'(count), 32'(MAXC));
      drive(1'b0, 3'd0, '0, '0);
      cycle(1'b1);

      // Reset mid-operation discards queued results
      out_ready = 1'b0;
      drive(1'b1, 3'd1, 8'h5A, 8'h00);
      cycle(1'b1);
      drive(1'b1, 3'd1, 8'hA5, 8'h00);
      cycle(1'b1);
      drive(1'b0, 3'd0, '0, '0);
      rst = 1'b1;
      cycle(1'b1);
      rst = 1'b0;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_y", 32'(y), 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) cycle(1'b1);

      // Reduction flags
      out_ready = 1'b0;
      drive(1'b1, 3'd2, 8'hAA, 8'hAA);
      cycle(1'b1);
      drive(1'b0, 3'd0, '0, '0);
`ifdef LOGIC_REDUCE_EN
      chk("xor_zero", 32'(y_zero), 32'd1);
`else
      chk("xor_zero", 32'(y_zero), 32'd0);
`endif
      chk("xor_ones", 32'(y_ones), 32'd0);
      out_ready = 1'b1;
      cycle(1'b1);
      out_ready = 1'b0;
      drive(1'b1, 3'd4, 8'h00, 8'h00);
      cycle(1'b1);
      drive(1'b0, 3'd0, '0, '0);
      chk("nor_y", 32'(y), 32'hFF);
`ifdef LOGIC_REDUCE_EN
      chk("nor_ones", 32'(y_ones), 32'd1);
`else
      chk("nor_ones", 32'(y_ones), 32'd0);
`endif
      chk("nor_zero", 32'(y_zero), 32'd0);
      out_ready = 1'b1;
      cycle(1'b1);

      // Randomized traffic with occasional reset
      for (int i = 0; i < 600; i++) begin
         rst       = ($urandom_range(0, 63) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         op        = 3'($urandom_range(0, 7));
         a         = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
         b         = ($urandom_range(0, 5) == 0) ? '1 : W'($urandom);
         cycle(1'b1);
      end
      rst = 1'b0;
      drive(1'b0, 3'd0, '0, '0);
      cycle(1'b1);
      cycle(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
